// File: rtl/agc_pkg.sv
// Shared widths, opcode and state encodings for the AGC control unit.
package agc_pkg;

   localparam int unsigned WORD_W = 15;
   localparam int unsigned ADDR_W = 12;

   localparam logic [WORD_W-1:0] NEG_ZERO  = 15'h7FFF;
   localparam logic [WORD_W-1:0] MINUS_ONE = 15'h7FFE;

   typedef enum logic [2:0] {
      OP_TC    = 3'b000,
      OP_CCS   = 3'b001,
      OP_INDEX = 3'b010,
      OP_CA    = 3'b011,
      OP_CS    = 3'b100,
      OP_TS    = 3'b101,
      OP_AD    = 3'b110,
      OP_MASK  = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_EXEC
   } state_e;

endpackage

// File: rtl/agc_control_unit_if.sv
// Instruction handshake, memory bus and register observation signals.
interface agc_control_unit_if;
   import agc_pkg::*;

   logic              instr_valid;
   logic              instr_ready;
   logic [2:0]        opcode;
   logic [1:0]        qc;
   logic              pc;
   logic [ADDR_W-1:0] addr12;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic [WORD_W-1:0] mem_rdata;
   logic [ADDR_W-1:0] z_out;
   logic [WORD_W-1:0] a_out;
   logic [ADDR_W-1:0] q_out;
   logic              illegal;

   modport master (
      output instr_valid, opcode, qc, pc, addr12, mem_rdata,
      input  instr_ready, mem_en, mem_we, mem_addr, mem_wdata,
             z_out, a_out, q_out, illegal
   );

   modport slave (
      input  instr_valid, opcode, qc, pc, addr12, mem_rdata,
      output instr_ready, mem_en, mem_we, mem_addr, mem_wdata,
             z_out, a_out, q_out, illegal
   );

endinterface

// File: rtl/ones_comp_adder.sv
// 15-bit ones-complement adder: carry out of the MSB is folded back in.
module ones_comp_adder
   import agc_pkg::*;
(
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   output logic [WORD_W-1:0] sum_o
);

   logic [WORD_W:0] raw;

   always_comb begin
      raw   = {1'b0, a_i} + {1'b0, b_i};
      sum_o = raw[WORD_W-1:0] + {{(WORD_W-1){1'b0}}, raw[WORD_W]};
   end

endmodule

// File: rtl/agc_control_unit.sv
// AGC-style control unit: accepts decoded instructions, sequences memory
// cycles and updates the Z, A, Q and index registers.
module agc_control_unit
   import agc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   agc_control_unit_if.slave bus
);

   state_e            state_q, state_d;
   opcode_e           op_q, op_d;
   logic [ADDR_W-1:0] z_q, z_d, q_q, q_d, index_q, index_d, ea_q, ea_d;
   logic [WORD_W-1:0] a_q, a_d;
   logic              illegal_q, illegal_d;
   logic              init_q;
   logic              ready, accept;
   logic [WORD_W-1:0] k, add_a, add_b, add_sum, ccs_dec, ccs_a;
   logic [ADDR_W-1:0] ccs_skip;
   logic              unused_qc;

   assign unused_qc = ^bus.qc;
   assign k         = bus.mem_rdata;
   assign ready     = (state_q == ST_IDLE) && init_q;
   assign accept    = bus.instr_valid && ready;

   // AD adds A+K; CCS decrements |K| by adding ones-complement -1
   always_comb begin
      add_a = a_q;
      add_b = k;
      if (op_q != OP_AD) begin
         add_a = k[WORD_W-1] ? ~k : k;
         add_b = MINUS_ONE;
      end
   end

   ones_comp_adder u_add (
      .a_i   (add_a),
      .b_i   (add_b),
      .sum_o (add_sum)
   );

   // |K| = 1 yields -0 from the end-around adder; CCS wants +0 there
   assign ccs_dec = (add_sum == NEG_ZERO) ? '0 : add_sum;

   always_comb begin
      ccs_a    = ccs_dec;
      ccs_skip = 12'd1;
      if (k == '0) begin
         ccs_a    = '0;
         ccs_skip = 12'd2;
      end else if (k == NEG_ZERO) begin
         ccs_a    = '0;
         ccs_skip = 12'd4;
      end else if (k[WORD_W-1]) begin
         ccs_skip = 12'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept && !bus.pc)
                      state_d = (opcode_e'(bus.opcode) == OP_TC) ? ST_EXEC : ST_ISSUE;
         ST_ISSUE: state_d = (op_q == OP_TS) ? ST_IDLE : ST_EXEC;
         ST_EXEC:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      op_d      = op_q;
      ea_d      = ea_q;
      index_d   = index_q;
      z_d       = z_q;
      a_d       = a_q;
      q_d       = q_q;
      illegal_d = 1'b0;
      if (accept) begin
         op_d = opcode_e'(bus.opcode);
         ea_d = bus.addr12 + index_q;
         if (op_d != OP_INDEX) index_d = '0;
         if (bus.pc) begin
            illegal_d = 1'b1;
            z_d       = z_q + 12'd1;
         end
      end
      if (state_q == ST_ISSUE && op_q == OP_TS) z_d = z_q + 12'd1;
      if (state_q == ST_EXEC) begin
         z_d = z_q + 12'd1;
         case (op_q)
            OP_TC:    begin q_d = z_q + 12'd1; z_d = ea_q; end
            OP_CCS:   begin a_d = ccs_a; z_d = z_q + ccs_skip; end
            OP_INDEX: index_d = k[ADDR_W-1:0];
            OP_CA:    a_d = k;
            OP_CS:    a_d = ~k;
            OP_AD:    a_d = add_sum;
            OP_MASK:  a_d = a_q & k;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_TC;
         ea_q      <= '0;
         index_q   <= '0;
         z_q       <= '0;
         a_q       <= '0;
         q_q       <= '0;
         illegal_q <= 1'b0;
         init_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         ea_q      <= ea_d;
         index_q   <= index_d;
         z_q       <= z_d;
         a_q       <= a_d;
         q_q       <= q_d;
         illegal_q <= illegal_d;
         init_q    <= 1'b1;
      end
   end

   assign bus.instr_ready = ready;
   assign bus.mem_en      = (state_q == ST_ISSUE);
   assign bus.mem_we      = (state_q == ST_ISSUE) && (op_q == OP_TS);
   assign bus.mem_addr    = ea_q;
   assign bus.mem_wdata   = a_q;
   assign bus.z_out       = z_q;
   assign bus.a_out       = a_q;
   assign bus.q_out       = q_q;
   assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_agc_control_unit.sv
// Bench for agc_control_unit: directed vector table, reset/handshake
// corner sequences and random instructions against an arithmetic model.
module tb_agc_control_unit;
   import agc_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   int unsigned n_checks = 0;
   int unsigned n_err    = 0;
   int unsigned m_z, m_a, m_q, m_index;

   agc_control_unit_if bus_if ();

   agc_control_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned op, pc, addr, k, z, a, q, cyc, wr, maddr, ill;
   } vec_t;

   localparam int NV = 22;
   vec_t        vecs [NV];
   logic [14:0] edge_k [6];

   function automatic vec_t mk(input int unsigned op, pc, addr, k, z, a, q,
                               cyc, wr, maddr, ill);
      vec_t v;
      v.op = op; v.pc = pc; v.addr = addr; v.k = k; v.z = z; v.a = a; v.q = q;
      v.cyc = cyc; v.wr = wr; v.maddr = maddr; v.ill = ill;
      return v;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endfunction

   task automatic do_reset();
      bus_if.instr_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst.ready", bus_if.instr_ready, 0);
      chk("rst.mem_en", bus_if.mem_en, 0);
      chk("rst.mem_we", bus_if.mem_we, 0);
      chk("rst.illegal", bus_if.illegal, 0);
      chk("rst.z", bus_if.z_out, 0);
      chk("rst.a", bus_if.a_out, 0);
      chk("rst.q", bus_if.q_out, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rst.ready_low_until_clk", bus_if.instr_ready, 0);
      @(posedge clk);
      #1 chk("rst.ready_rise", bus_if.instr_ready, 1);
   endtask

   task automatic run_instr(input logic [2:0] op, input logic pcb,
                            input logic [11:0] addr, input logic [14:0] k,
                            output int cyc, output int n_rd, output int n_wr,
                            output logic [11:0] maddr, output logic [14:0] wdata,
                            output logic ill);
      int   w;
      logic rd_now;
      cyc = 0; n_rd = 0; n_wr = 0; maddr = '0; wdata = '0; ill = 1'b0;
      bus_if.mem_rdata = ~k;
      @(negedge clk);
      w = 0;
      while (!bus_if.instr_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!bus_if.instr_ready) begin
         chk("ready_timeout", bus_if.instr_ready, 1);
         return;
      end
      bus_if.instr_valid = 1'b1;
      bus_if.opcode      = op;
      bus_if.pc          = pcb;
      bus_if.addr12      = addr;
      bus_if.qc          = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1 bus_if.instr_valid = 1'b0;
      cyc = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus_if.illegal) ill = 1'b1;
         if (bus_if.instr_ready) break;
         cyc++;
         rd_now = 1'b0;
         if (bus_if.mem_we && !bus_if.mem_en) n_wr++;
         if (bus_if.mem_en) begin
            maddr = bus_if.mem_addr;
            if (bus_if.mem_we) begin
               n_wr++;
               wdata = bus_if.mem_wdata;
            end else begin
               n_rd++;
               rd_now = 1'b1;
            end
         end
         @(posedge clk);
         #1 bus_if.mem_rdata = rd_now ? k : ~k;
      end
      if (!bus_if.instr_ready) chk("done_timeout", bus_if.instr_ready, 1);
   endtask

   // Ones-complement semantics computed as plain integer arithmetic.
   task automatic model_step(input logic [2:0] op, input logic pcb,
                             input logic [11:0] addr, input logic [14:0] k,
                             output int e_cyc, output int e_rd, output int e_wr,
                             output int unsigned e_maddr, output int unsigned e_wdata,
                             output logic e_ill);
      int unsigned kk, ea, s;
      kk      = k;
      ea      = (addr + m_index) % 4096;
      e_maddr = ea;
      e_wdata = m_a;
      e_rd = 0; e_wr = 0; e_ill = 1'b0; e_cyc = 3;
      if (op != 3'b010) m_index = 0;
      if (pcb) begin
         e_ill = 1'b1; e_cyc = 1; m_z = (m_z + 1) % 4096;
      end else if (op == 3'b000) begin
         e_cyc = 2; m_q = (m_z + 1) % 4096; m_z = ea;
      end else if (op == 3'b101) begin
         e_cyc = 2; e_wr = 1; m_z = (m_z + 1) % 4096;
      end else begin
         e_rd = 1;
         case (op)
            3'b001: if (kk == 0) begin m_a = 0; m_z += 2; end
                    else if (kk == 32'h7FFF) begin m_a = 0; m_z += 4; end
                    else if (kk < 32'h4000) begin m_a = kk - 1; m_z += 1; end
                    else begin m_a = (32'h7FFF - kk) - 1; m_z += 3; end
            3'b010: begin m_index = kk % 4096; m_z += 1; end
            3'b011: begin m_a = kk; m_z += 1; end
            3'b100: begin m_a = 32'h7FFF - kk; m_z += 1; end
            3'b110: begin
               s = m_a + kk;
               if (s > 32'h7FFF) s = s - 32'h8000 + 1;
               m_a = s; m_z += 1;
            end
            default: begin m_a = m_a & kk; m_z += 1; end
         endcase
         m_z = m_z % 4096;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc, n_rd, n_wr, e_cyc, e_rd, e_wr;
      int unsigned e_maddr, e_wdata;
      logic [11:0] maddr;
      logic [14:0] wdata;
      logic        ill, e_ill;
      logic [2:0]  op, sel;
      logic        pcb;
      logic [11:0] addr;
      logic [14:0] k;
      string       nm;

      bus_if.instr_valid = 1'b0;
      bus_if.opcode      = '0;
      bus_if.qc          = '0;
      bus_if.pc          = 1'b0;
      bus_if.addr12      = '0;
      bus_if.mem_rdata   = '0;
      edge_k = '{15'h0000, 15'h0001, 15'h7FFE, 15'h7FFF, 15'h4000, 15'h3FFF};

      //          op pc addr   k        z      a        q      cyc wr maddr  ill
      vecs[0]  = mk(0, 0, 'h010, 'h0000, 'h010, 'h0000, 'h001, 2, 0, 'h000, 0);
      vecs[1]  = mk(0, 0, 'h123, 'h0000, 'h123, 'h0000, 'h011, 2, 0, 'h000, 0);
      vecs[2]  = mk(3, 0, 'h200, 'h1234, 'h124, 'h1234, 'h011, 3, 0, 'h200, 0);
      vecs[3]  = mk(6, 0, 'h201, 'h7FFE, 'h125, 'h1233, 'h011, 3, 0, 'h201, 0);
      vecs[4]  = mk(1, 0, 'h202, 'h0005, 'h126, 'h0004, 'h011, 3, 0, 'h202, 0);
      vecs[5]  = mk(1, 0, 'h203, 'h0000, 'h128, 'h0000, 'h011, 3, 0, 'h203, 0);
      vecs[6]  = mk(1, 0, 'h204, 'h7FFA, 'h12B, 'h0004, 'h011, 3, 0, 'h204, 0);
      vecs[7]  = mk(1, 0, 'h205, 'h7FFF, 'h12F, 'h0000, 'h011, 3, 0, 'h205, 0);
      vecs[8]  = mk(3, 0, 'h206, 'h0055, 'h130, 'h0055, 'h011, 3, 0, 'h206, 0);
      vecs[9]  = mk(2, 0, 'h207, 'h0002, 'h131, 'h0055, 'h011, 3, 0, 'h207, 0);
      vecs[10] = mk(5, 0, 'h100, 'h0000, 'h132, 'h0055, 'h011, 2, 1, 'h102, 0);
      vecs[11] = mk(5, 0, 'h100, 'h0000, 'h133, 'h0055, 'h011, 2, 1, 'h100, 0);
      vecs[12] = mk(3, 1, 'h007, 'h1111, 'h134, 'h0055, 'h011, 1, 0, 'h000, 1);
      vecs[13] = mk(4, 0, 'h300, 'h00FF, 'h135, 'h7F00, 'h011, 3, 0, 'h300, 0);
      vecs[14] = mk(7, 0, 'h301, 'h0F0F, 'h136, 'h0F00, 'h011, 3, 0, 'h301, 0);
      vecs[15] = mk(6, 0, 'h302, 'h7FFF, 'h137, 'h0F00, 'h011, 3, 0, 'h302, 0);
      vecs[16] = mk(0, 0, 'hFFF, 'h0000, 'hFFF, 'h0F00, 'h138, 2, 0, 'h000, 0);
      vecs[17] = mk(3, 0, 'h303, 'h0001, 'h000, 'h0001, 'h138, 3, 0, 'h303, 0);
      vecs[18] = mk(1, 0, 'h304, 'h0001, 'h001, 'h0000, 'h138, 3, 0, 'h304, 0);
      vecs[19] = mk(1, 0, 'h305, 'h7FFE, 'h004, 'h0000, 'h138, 3, 0, 'h305, 0);
      vecs[20] = mk(2, 0, 'h306, 'h7FFF, 'h005, 'h0000, 'h138, 3, 0, 'h306, 0);
      vecs[21] = mk(5, 0, 'h003, 'h0000, 'h006, 'h0000, 'h138, 2, 1, 'h002, 0);

      #1;
      do_reset();

      for (int i = 0; i < NV; i++) begin
         run_instr(3'(vecs[i].op), 1'(vecs[i].pc), 12'(vecs[i].addr), 15'(vecs[i].k),
                   cyc, n_rd, n_wr, maddr, wdata, ill);
         nm = $sformatf("vec%0d", i);
         chk({nm, ".z"}, bus_if.z_out, vecs[i].z);
         chk({nm, ".a"}, bus_if.a_out, vecs[i].a);
         chk({nm, ".q"}, bus_if.q_out, vecs[i].q);
         chk({nm, ".cycles"}, cyc, vecs[i].cyc);
         chk({nm, ".illegal"}, ill, vecs[i].ill);
         chk({nm, ".writes"}, n_wr, vecs[i].wr);
         chk({nm, ".reads"}, n_rd, (vecs[i].cyc == 3) ? 1 : 0);
         if (vecs[i].cyc == 3 || vecs[i].wr == 1)
            chk({nm, ".mem_addr"}, maddr, vecs[i].maddr);
         if (vecs[i].wr == 1)
            chk({nm, ".mem_wdata"}, wdata, vecs[i].a);
         if (vecs[i].ill == 1) begin
            @(negedge clk);
            chk({nm, ".illegal_width"}, bus_if.illegal, 0);
         end
      end

      // instr_valid held high while busy, with a different opcode, is ignored
      @(negedge clk);
      bus_if.instr_valid = 1'b1;
      bus_if.opcode      = 3'b011;
      bus_if.pc          = 1'b0;
      bus_if.addr12      = 12'h020;
      bus_if.mem_rdata   = ~15'h0ABC;
      @(posedge clk);
      #1 bus_if.opcode = 3'b100;
      @(posedge clk);
      #1 bus_if.mem_rdata = 15'h0ABC;
      @(negedge clk);
      bus_if.instr_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("busy_valid.a", bus_if.a_out, 'h0ABC);
      chk("busy_valid.z", bus_if.z_out, 'h007);
      chk("busy_valid.ready", bus_if.instr_ready, 1);
      @(negedge clk);
      chk("busy_valid.no_reissue", bus_if.mem_en, 0);

      // reset asserted while a CA is in ISSUE aborts it
      do_reset();
      @(negedge clk);
      bus_if.instr_valid = 1'b1;
      bus_if.opcode      = 3'b011;
      bus_if.pc          = 1'b0;
      bus_if.addr12      = 12'h050;
      bus_if.mem_rdata   = 15'h1234;
      @(posedge clk);
      #1 bus_if.instr_valid = 1'b0;
      chk("abort.issue_strobe", bus_if.mem_en, 1);
      rst_n = 1'b0;
      #1;
      chk("abort.mem_en", bus_if.mem_en, 0);
      chk("abort.mem_we", bus_if.mem_we, 0);
      chk("abort.ready", bus_if.instr_ready, 0);
      chk("abort.a", bus_if.a_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort.ready_still_low", bus_if.instr_ready, 0);
      @(posedge clk);
      #1 chk("abort.ready_rise", bus_if.instr_ready, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort.a_hold", bus_if.a_out, 0);
         chk("abort.z_hold", bus_if.z_out, 0);
         chk("abort.no_strobe", bus_if.mem_en, 0);
      end

      do_reset();
      m_z = 0; m_a = 0; m_q = 0; m_index = 0;
      for (int i = 0; i < 250; i++) begin
         op   = 3'($urandom_range(0, 7));
         pcb  = ($urandom_range(0, 9) == 0);
         if (pcb && op == 3'b010) op = 3'b011;
         addr = 12'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            sel = 3'($urandom_range(0, 5));
            k   = edge_k[sel];
         end else begin
            k = 15'($urandom);
         end
         model_step(op, pcb, addr, k, e_cyc, e_rd, e_wr, e_maddr, e_wdata, e_ill);
         run_instr(op, pcb, addr, k, cyc, n_rd, n_wr, maddr, wdata, ill);
         nm = $sformatf("rnd%0d(op%0d)", i, op);
         chk({nm, ".z"}, bus_if.z_out, m_z);
         chk({nm, ".a"}, bus_if.a_out, m_a);
         chk({nm, ".q"}, bus_if.q_out, m_q);
         chk({nm, ".cycles"}, cyc, e_cyc);
         chk({nm, ".illegal"}, ill, e_ill);
         chk({nm, ".reads"}, n_rd, e_rd);
         chk({nm, ".writes"}, n_wr, e_wr);
         if (e_rd == 1 || e_wr == 1) chk({nm, ".mem_addr"}, maddr, e_maddr);
         if (e_wr == 1) chk({nm, ".mem_wdata"}, wdata, e_wdata);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
